// File: rtl/link_anim_ctrl.sv
// -----------------------------------------------------------------------------
// link_anim_ctrl
//
// Animation and sprite-fetch controller for the player character.
//
// Once per video frame (on the vsync falling edge) it advances a small
// IDLE / WALK / ATTACK state machine. That machine tracks the facing
// direction, the two-phase walk cycle and the attack duration. It publishes
// {facing, walk_frame} as the ROM/palette select for the color mapper.
//
// Every pixel it produces the sprite ROM address for the current DrawX/DrawY.
// It also produces a coverage flag that is delayed by one cycle, so that the
// flag lines up with the ROM's registered read data.
//
// Ports
//   vga_clk        in   1   pixel clock (single clock domain)
//   Reset          in   1   synchronous, active-high reset
//   vsync          in   1   raw VGA vsync, active low
//   blank          in   1   high during active video
//   DrawX, DrawY   in  10   current pixel coordinate
//   link_x, link_y in  10   sprite top-left coordinate
//   dir_in         in   2   requested facing: 0 up, 1 down, 2 left, 3 right
//   move_req       in   1   level: player is moving
//   attack_req     in   1   level: attack button
//   rom_address    out 10   sprite ROM address (combinational)
//   sprite_sel     out  3   {facing[1:0], walk_frame}: ROM/palette pair select
//   attack_active  out  1   high while attacking; renderer picks attack sprite
//   sprite_on      out  1   registered coverage flag, aligned with ROM q
// -----------------------------------------------------------------------------
module link_anim_ctrl #(
  parameter int SPRITE_W     = 32,  // power of two
  parameter int SPRITE_H     = 32,
  parameter int STEP_TICKS   = 8,   // frames per walk-frame toggle, >= 1
  parameter int ATTACK_TICKS = 16   // frames an attack lasts, >= 1
) (
  input  logic       vga_clk,
  input  logic       Reset,
  input  logic       vsync,
  input  logic       blank,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  input  logic [9:0] link_x,
  input  logic [9:0] link_y,
  input  logic [1:0] dir_in,
  input  logic       move_req,
  input  logic       attack_req,
  output logic [9:0] rom_address,
  output logic [2:0] sprite_sel,
  output logic       attack_active,
  output logic       sprite_on
);

  // The frame counter only ever holds values up to max(STEP, ATTACK)-1.
  // It is kept at least 5 bits wide regardless.
  localparam int MAX_TICKS = (STEP_TICKS > ATTACK_TICKS) ? STEP_TICKS : ATTACK_TICKS;
  localparam int CNT_W     = ($clog2(MAX_TICKS) > 5) ? $clog2(MAX_TICKS) : 5;
  localparam logic [CNT_W-1:0] STEP_LAST   = CNT_W'(STEP_TICKS - 1);
  localparam logic [CNT_W-1:0] ATTACK_LAST = CNT_W'(ATTACK_TICKS - 1);
  // Row stride in the ROM is SPRITE_W, so the row offset is a plain shift.
  localparam int X_SHIFT = $clog2(SPRITE_W);

  localparam logic [1:0] FACE_DOWN = 2'd1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WALK   = 2'd1,
    S_ATTACK = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Frame tick: a one-cycle pulse on the vsync falling edge.
  // r_vs_d resets low, so a vsync that is already low when reset releases
  // does not produce a spurious tick.
  // ---------------------------------------------------------------------------
  logic r_vs_d;
  logic w_tick;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge vga_clk) begin
    if (Reset) r_vs_d <= 1'b0;
    else       r_vs_d <= vsync;
  end

  assign w_tick = r_vs_d & ~vsync;

  // ---------------------------------------------------------------------------
  // Animation state machine: register process
  // ---------------------------------------------------------------------------
  state_t           r_state;
  logic [1:0]       r_facing;
  logic             r_frame;
  logic [CNT_W-1:0] r_cnt;
  logic             r_attack_active;

  state_t           w_state_nxt;
  logic [1:0]       w_facing_nxt;
  logic             w_frame_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;

  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      r_state         <= S_IDLE;
      r_facing        <= FACE_DOWN;
      r_frame         <= 1'b0;
      r_cnt           <= '0;
      r_attack_active <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_facing        <= w_facing_nxt;
      r_frame         <= w_frame_nxt;
      r_cnt           <= w_cnt_nxt;
      r_attack_active <= (w_state_nxt == S_ATTACK);
    end
  end

  // ---------------------------------------------------------------------------
  // Animation state machine: next-state process.
  // Nothing moves except on a tick, so the sprite never switches mid-frame.
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned here gets a default first. A path that leaves
  // a signal unassigned would infer a latch.
  always_comb begin
    w_state_nxt  = r_state;
    w_facing_nxt = r_facing;
    w_frame_nxt  = r_frame;
    w_cnt_nxt    = r_cnt;

    if (w_tick) begin
      unique case (r_state)
        S_IDLE: begin
          w_frame_nxt = 1'b0;
          if (attack_req) begin
            w_state_nxt  = S_ATTACK;
            w_cnt_nxt    = '0;
            w_facing_nxt = dir_in;
          end else if (move_req) begin
            w_state_nxt  = S_WALK;
            w_cnt_nxt    = '0;
            w_facing_nxt = dir_in;
          end
        end

        S_WALK: begin
          if (attack_req) begin
            w_state_nxt  = S_ATTACK;
            w_cnt_nxt    = '0;
            w_frame_nxt  = 1'b0;
            w_facing_nxt = dir_in;
          end else if (!move_req) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
            w_frame_nxt = 1'b0;
          end else begin
            // Walking steers freely. The frame flips every STEP_TICKS ticks.
            w_facing_nxt = dir_in;
            if (r_cnt == STEP_LAST) begin
              w_cnt_nxt   = '0;
              w_frame_nxt = ~r_frame;
            end else begin
              w_cnt_nxt = r_cnt + 1'b1;
            end
          end
        end

        S_ATTACK: begin
          // Facing is frozen, and attack_req / dir_in are ignored.
          // A held button can only re-trigger from the tick after the exit.
          if (r_cnt == ATTACK_LAST) begin
            w_state_nxt  = move_req ? S_WALK : S_IDLE;
            w_cnt_nxt    = '0;
            w_frame_nxt  = 1'b0;
            w_facing_nxt = dir_in;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end

        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
          w_frame_nxt = 1'b0;
        end
      endcase
    end
  end

  assign sprite_sel    = {r_facing, r_frame};
  assign attack_active = r_attack_active;

  // ---------------------------------------------------------------------------
  // Pixel path: coverage test and ROM address.
  // The right and bottom bounds are summed in 11 bits. A sprite placed near
  // the screen edge must not wrap around and hit pixels at column/row 0.
  // ---------------------------------------------------------------------------
  logic [10:0] w_x_end;
  logic [10:0] w_y_end;
  logic        w_in_box;
  logic [9:0]  w_dx;
  logic [9:0]  w_dy;
  logic [9:0]  w_dy_sh;
  logic        r_sprite_on;

  assign w_x_end = {1'b0, link_x} + 11'(SPRITE_W);
  assign w_y_end = {1'b0, link_y} + 11'(SPRITE_H);

  assign w_in_box = blank
                  && (DrawX >= link_x) && ({1'b0, DrawX} < w_x_end)
                  && (DrawY >= link_y) && ({1'b0, DrawY} < w_y_end);

  // The address is a don't-care outside the box, so plain wrapping
  // subtraction is enough.
  assign w_dx        = DrawX - link_x;
  assign w_dy        = DrawY - link_y;
  assign w_dy_sh     = w_dy << X_SHIFT;
  assign rom_address = w_dy_sh + w_dx;

  // The coverage flag is delayed one cycle to line up with the ROM's
  // registered read data.
  always_ff @(posedge vga_clk) begin
    if (Reset) r_sprite_on <= 1'b0;
    else       r_sprite_on <= w_in_box;
  end

  assign sprite_on = r_sprite_on;

endmodule

// File: tb/tb_link_anim_ctrl.sv
// -----------------------------------------------------------------------------
// tb_link_anim_ctrl
//
// Scoreboard bench for link_anim_ctrl.
//
// At each frame tick the bench steps a reference model of the animation
// machine and queues the expected {attack_active, sprite_sel}. That entry is
// popped and compared once the DUT's registers have taken the tick.
//
// For pixel stimulus the bench queues the expected coverage flag. It is popped
// one cycle later to match the one-cycle delay on sprite_on. The ROM address
// is checked immediately, because it is combinational.
// -----------------------------------------------------------------------------
module tb_link_anim_ctrl;

  logic       vga_clk;
  logic       Reset;
  logic       vsync;
  logic       blank;
  logic [9:0] DrawX, DrawY, link_x, link_y;
  logic [1:0] dir_in;
  logic       move_req, attack_req;
  logic [9:0] rom_address;
  logic [2:0] sprite_sel;
  logic       attack_active;
  logic       sprite_on;

  link_anim_ctrl #(
    .SPRITE_W(32), .SPRITE_H(32), .STEP_TICKS(8), .ATTACK_TICKS(16)
  ) dut (
    .vga_clk      (vga_clk),
    .Reset        (Reset),
    .vsync        (vsync),
    .blank        (blank),
    .DrawX        (DrawX),
    .DrawY        (DrawY),
    .link_x       (link_x),
    .link_y       (link_y),
    .dir_in       (dir_in),
    .move_req     (move_req),
    .attack_req   (attack_req),
    .rom_address  (rom_address),
    .sprite_sel   (sprite_sel),
    .attack_active(attack_active),
    .sprite_on    (sprite_on)
  );

  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model of the frame-rate animation behaviour
  // ---------------------------------------------------------------------------
  localparam int M_IDLE = 0, M_WALK = 1, M_ATK = 2;
  int         m_state;
  logic [1:0] m_face;
  logic       m_frame;
  int         m_cnt;

  task automatic model_reset();
    m_state = M_IDLE;
    m_face  = 2'd1;
    m_frame = 1'b0;
    m_cnt   = 0;
  endtask

  task automatic model_tick();
    case (m_state)
      M_IDLE: begin
        m_frame = 1'b0;
        if (attack_req) begin
          m_state = M_ATK; m_cnt = 0; m_face = dir_in;
        end else if (move_req) begin
          m_state = M_WALK; m_cnt = 0; m_face = dir_in;
        end
      end
      M_WALK: begin
        if (attack_req) begin
          m_state = M_ATK; m_cnt = 0; m_frame = 1'b0; m_face = dir_in;
        end else if (!move_req) begin
          m_state = M_IDLE; m_cnt = 0; m_frame = 1'b0;
        end else begin
          m_face = dir_in;
          if (m_cnt == 7) begin
            m_cnt = 0; m_frame = ~m_frame;
          end else begin
            m_cnt++;
          end
        end
      end
      default: begin
        if (m_cnt == 15) begin
          m_state = move_req ? M_WALK : M_IDLE;
          m_cnt = 0; m_frame = 1'b0; m_face = dir_in;
        end else begin
          m_cnt++;
        end
      end
    endcase
  endtask

  logic [3:0] q_sel[$];
  logic       q_on[$];

  // One frame tick: vsync falls, outputs are compared one cycle later, and
  // vsync returns high so that the next falling edge is seen.
  task automatic do_tick();
    logic [3:0] e;
    @(negedge vga_clk);
    vsync = 1'b0;
    model_tick();
    q_sel.push_back({(m_state == M_ATK), m_face, m_frame});
    @(negedge vga_clk);
    e = q_sel.pop_front();
    check("sel", 32'(sprite_sel), 32'(e[2:0]));
    check("atk", 32'(attack_active), 32'(e[3]));
    vsync = 1'b1;
    @(negedge vga_clk);
  endtask

  // ---------------------------------------------------------------------------
  // Pixel stimulus
  // ---------------------------------------------------------------------------
  int lx, ly;

  task automatic pop_on();
    logic e;
    if (q_on.size() > 0) begin
      e = q_on.pop_front();
      check("sprite_on", 32'(sprite_on), 32'(e));
    end
  endtask

  task automatic pix(input int x, input int y, input logic b);
    logic exp_in;
    @(negedge vga_clk);
    pop_on();
    DrawX = 10'(x);
    DrawY = 10'(y);
    blank = b;
    exp_in = b && (x >= lx) && (x < lx + 32) && (y >= ly) && (y < ly + 32);
    #1;
    if (exp_in) check("rom", 32'(rom_address), 32'((y - ly) * 32 + (x - lx)));
    q_on.push_back(exp_in);
  endtask

  task automatic flush_pix();
    @(negedge vga_clk);
    pop_on();
    blank = 1'b0;
  endtask

  // Guard against a hung run.
  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1, "watchdog");
  end

  int n_atk;

  initial begin
    // ---------------- reset held, vsync low, sprite inside the box ----------
    Reset = 1'b1; vsync = 1'b0; blank = 1'b1;
    link_x = 10'd0; link_y = 10'd0; DrawX = 10'd5; DrawY = 10'd5;
    dir_in = 2'd0; move_req = 1'b1; attack_req = 1'b0;
    lx = 0; ly = 0;
    model_reset();
    repeat (3) @(negedge vga_clk);
    check("rst_sprite_on", 32'(sprite_on), 32'd0);
    check("rst_sel", 32'(sprite_sel), 32'b010);
    check("rst_atk", 32'(attack_active), 32'd0);
    blank = 1'b0;
    @(negedge vga_clk);
    Reset = 1'b0;
    // vsync remains low: there must be no tick, even with move_req high.
    for (int i = 0; i < 4; i++) begin
      @(negedge vga_clk);
      check("no_tick_sel", 32'(sprite_sel), 32'b010);
      check("no_tick_atk", 32'(attack_active), 32'd0);
      check("no_tick_on", 32'(sprite_on), 32'd0);
    end
    move_req = 1'b0;
    vsync = 1'b1;
    repeat (2) @(negedge vga_clk);

    // ---------------- walking left for 20 ticks -----------------------------
    dir_in = 2'd2; move_req = 1'b1;
    for (int t = 1; t <= 20; t++) begin
      do_tick();
      if (t == 1)  check("walk_t1", 32'(sprite_sel), 32'b100);
      if (t == 9)  check("walk_t9", 32'(sprite_sel), 32'b101);
      if (t == 17) check("walk_t17", 32'(sprite_sel), 32'b100);
    end
    // A mid-frame direction change waits for the next tick.
    dir_in = 2'd3;
    repeat (3) @(negedge vga_clk);
    check("dir_hold", 32'(sprite_sel), 32'b100);
    do_tick();
    check("dir_next", 32'(sprite_sel), 32'b110);

    // ---------------- attack during walk, exit to WALK ----------------------
    attack_req = 1'b1;
    do_tick();
    attack_req = 1'b0;
    dir_in = 2'd0;
    n_atk = attack_active ? 1 : 0;
    for (int t = 0; t < 20; t++) begin
      do_tick();
      if (attack_active) begin
        n_atk++;
        check("atk_face", 32'(sprite_sel), 32'b110);
      end
    end
    check("atk_len_walk", 32'(n_atk), 32'd16);
    check("atk_exit_walk", 32'(sprite_sel), 32'b000);

    // Walk until frame 1, then attack and exit to IDLE.
    repeat (4) do_tick();
    check("pre_atk_frame", 32'(sprite_sel), 32'b001);
    move_req = 1'b0; attack_req = 1'b1;
    do_tick();
    attack_req = 1'b0;
    dir_in = 2'd3;
    n_atk = attack_active ? 1 : 0;
    for (int t = 0; t < 18; t++) begin
      do_tick();
      if (attack_active) n_atk++;
    end
    check("atk_len_idle", 32'(n_atk), 32'd16);
    check("atk_exit_idle", 32'(sprite_sel), 32'b110);
    // In IDLE the facing direction no longer follows dir_in.
    dir_in = 2'd0;
    do_tick();
    check("idle_hold", 32'(sprite_sel), 32'b110);

    // ---------------- pixel sweep, sprite at (100,50) -----------------------
    lx = 100; ly = 50;
    link_x = 10'd100; link_y = 10'd50;
    pix(100, 50, 1'b1);
    check("rom_origin", 32'(rom_address), 32'd0);
    pix(131, 81, 1'b1);
    check("rom_last", 32'(rom_address), 32'd1023);
    for (int x = 98; x <= 133; x++) pix(x, 50, 1'b1);
    for (int x = 97; x <= 134; x += 3) pix(x, 81, 1'b1);
    for (int x = 100; x <= 105; x++) pix(x, 60, 1'b0);
    pix(110, 49, 1'b1);
    pix(110, 82, 1'b1);
    pix(107, 66, 1'b1);
    flush_pix();

    // ---------------- sprite near the right edge ----------------------------
    lx = 620; ly = 50;
    link_x = 10'd620;
    for (int x = 615; x <= 639; x++) pix(x, 55, 1'b1);
    for (int x = 0; x <= 11; x++) pix(x, 55, 1'b1);
    flush_pix();

    // ---------------- reset colliding with a tick in ATTACK -----------------
    attack_req = 1'b1; move_req = 1'b0; dir_in = 2'd0;
    do_tick();
    attack_req = 1'b0;
    repeat (2) do_tick();
    @(negedge vga_clk);
    vsync = 1'b0;
    Reset = 1'b1;
    @(negedge vga_clk);
    Reset = 1'b0;
    vsync = 1'b1;
    model_reset();
    check("rst_tick_sel", 32'(sprite_sel), 32'b010);
    check("rst_tick_atk", 32'(attack_active), 32'd0);
    @(negedge vga_clk);
    do_tick();
    // Walking must restart from a cleared counter: the first toggle comes
    // on the ninth tick.
    move_req = 1'b1; dir_in = 2'd2;
    for (int t = 1; t <= 9; t++) begin
      do_tick();
      if (t == 8) check("post_rst_t8", 32'(sprite_sel), 32'b100);
      if (t == 9) check("post_rst_t9", 32'(sprite_sel), 32'b101);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
